regblock_monitor: RTL

Passive read-side checker for the two-entry regblock register file. It snoops the write port (wr_index, en, d) and the read port (rd_index, q) of one regblock instance and keeps a shadow copy of both entries. Every read is compared against the shadow, and the first divergence is captured. One monitor instance attaches to each side of the dual-instance equivalence harness. It also runs standalone in simulation as a scoreboard.

---
 rtl/regblock_pkg.sv | 11 +
 rtl/regblock_shadow.sv | 35 +++
 rtl/regblock_monitor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/regblock_pkg.sv
// Shared types and constants for the regblock read-side monitor.
package regblock_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } state_t;

  localparam int NUM_ENTRIES = 2;
  localparam int IDX_W       = $clog2(NUM_ENTRIES);
endpackage

// File: rtl/regblock_shadow.sv
// Shadow copy of the two regblock entries with per-entry valid bits.
module regblock_shadow
  import regblock_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [IDX_W-1:0] wr_index,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic [IDX_W-1:0] rd_index,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);
  logic [WIDTH-1:0]       data [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) data[i] <= '0;
      valid <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (en) begin
      data[wr_index]  <= d;
      valid[wr_index] <= 1'b1;
    end
  end

  // Read sees the pre-write contents, so a same-edge write yields the old value.
  assign rd_data  = data[rd_index];
  assign rd_valid = valid[rd_index];
endmodule

// File: rtl/regblock_monitor.sv
// Passive checker comparing regblock reads against a shadow copy; captures first divergence.
module regblock_monitor
  import regblock_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int READ_LATENCY = 0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_en,
  input  logic             clear,
  input  logic             wr_index,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             rd_index,
  input  logic [WIDTH-1:0] q,
  output logic             mismatch,
  output logic             err_sticky,
  output logic             err_index,
  output logic [WIDTH-1:0] err_expected,
  output logic [WIDTH-1:0] err_actual,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count
);
  state_t           state;
  logic [WIDTH-1:0] sh_data;
  logic             sh_valid;
  logic             active;
  logic             pend_v;
  logic             pend_idx;
  logic [WIDTH-1:0] pend_exp;
  logic             cmp_v;
  logic             cmp_idx;
  logic [WIDTH-1:0] cmp_exp;
  logic             fail;

  regblock_shadow #(.WIDTH(WIDTH)) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .wr_index (wr_index),
    .en       (en),
    .d        (d),
    .rd_index (rd_index),
    .rd_data  (sh_data),
    .rd_valid (sh_valid)
  );

  assign active = (state == RUN) || (state == FAIL);

  // Latency-1 pipeline: arming is judged in the read cycle, so a compare
  // already in flight completes even if chk_en drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v   <= 1'b0;
      pend_idx <= 1'b0;
      pend_exp <= '0;
    end else if (clear) begin
      pend_v   <= 1'b0;
    end else begin
      pend_v   <= active && sh_valid && chk_en;
      pend_idx <= rd_index;
      pend_exp <= sh_data;
    end
  end

  always_comb begin
    cmp_v   = 1'b0;
    cmp_idx = 1'b0;
    cmp_exp = '0;
    if (READ_LATENCY == 0) begin
      cmp_v   = active && sh_valid;
      cmp_idx = rd_index;
      cmp_exp = sh_data;
    end else begin
      cmp_v   = pend_v;
      cmp_idx = pend_idx;
      cmp_exp = pend_exp;
    end
  end

  assign fail = cmp_v && (q != cmp_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mismatch     <= 1'b0;
      err_sticky   <= 1'b0;
      err_index    <= 1'b0;
      err_expected <= '0;
      err_actual   <= '0;
      chk_count    <= '0;
      err_count    <= '0;
    end else if (clear) begin
      state        <= IDLE;
      mismatch     <= 1'b0;
      err_sticky   <= 1'b0;
      err_index    <= 1'b0;
      err_expected <= '0;
      err_actual   <= '0;
      chk_count    <= '0;
      err_count    <= '0;
    end else begin
      mismatch <= fail;
      if (cmp_v && (chk_count != '1)) chk_count <= chk_count + 1'b1;
      if (fail && (err_count != '1)) err_count <= err_count + 1'b1;
      case (state)
        IDLE: if (chk_en) state <= RUN;
        RUN: begin
          if (fail) begin
            state        <= FAIL;
            err_sticky   <= 1'b1;
            err_index    <= cmp_idx;
            err_expected <= cmp_exp;
            err_actual   <= q;
          end else if (!chk_en) begin
            state <= IDLE;
          end
        end
        FAIL:    state <= FAIL;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
